// File: rtl/sprite_compositor_pipe.sv
// Three-stage per-pixel sprite compositor: hit-test and ROM addressing, ROM read, colour mux.
// Also owns the background scroll divider and the sticky win/lose end-screen state.
module sprite_compositor_pipe #(
  parameter int unsigned COORD_W    = 11,
  parameter int unsigned MAX_SEG    = 23,
  parameter int unsigned SPR_LOG2   = 5,
  parameter int unsigned BG_W_LOG2  = 6,
  parameter int unsigned BG_H_LOG2  = 6,
  parameter int unsigned SCROLL_DIV = 1000000,
  parameter logic [11:0] TRANSP     = 12'h000,
  parameter logic [11:0] WIN_RGB    = 12'h0F0,
  parameter logic [11:0] LOSE_RGB   = 12'hF00
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pix_valid,
  input  logic [COORD_W-1:0]             curr_x,
  input  logic [COORD_W-1:0]             curr_y,
  input  logic [COORD_W*MAX_SEG-1:0]     snakepos_x,
  input  logic [COORD_W*MAX_SEG-1:0]     snakepos_y,
  input  logic [5:0]                     length,
  input  logic [COORD_W-1:0]             applepos_x,
  input  logic [COORD_W-1:0]             applepos_y,
  input  logic                           lose,
  input  logic                           win,
  output logic [2*SPR_LOG2-1:0]          spr_addr,
  output logic [BG_W_LOG2+BG_H_LOG2-1:0] bg_addr,
  input  logic [11:0]                    apple_pix,
  input  logic [11:0]                    head_pix,
  input  logic [11:0]                    body_pix,
  input  logic [11:0]                    bg_pix,
  output logic [3:0]                     draw_r,
  output logic [3:0]                     draw_g,
  output logic [3:0]                     draw_b,
  output logic                           draw_valid
);

  localparam int unsigned SPR_SIZE = 1 << SPR_LOG2;
  localparam int unsigned DIV_W    = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

  typedef enum logic [1:0] {StPlay, StWin, StLose} state_e;

  state_e                 state_q;
  logic [DIV_W-1:0]       div_q;
  logic [BG_W_LOG2-1:0]   scroll_q;
  logic                   v1_q, v2_q;
  logic                   apple_hit_q, head_hit_q, body_hit_q;
  logic                   apple_hit2_q, head_hit2_q, body_hit2_q;

  logic                   apple_hit, head_hit, body_hit;
  logic [COORD_W-1:0]     body_px, body_py;
  logic [2*SPR_LOG2-1:0]  spr_addr_d;
  logic [BG_W_LOG2-1:0]   bg_col;
  logic [11:0]            draw_d;

  // Extra top bit keeps pos + sprite size from wrapping at the right/bottom edge.
  function automatic logic in_box(input logic [COORD_W-1:0] p, input logic [COORD_W-1:0] pos);
    logic [COORD_W:0] pe, pose;
    pe   = {1'b0, p};
    pose = {1'b0, pos};
    return (pe >= pose) && (pe < pose + (COORD_W+1)'(SPR_SIZE));
  endfunction

  function automatic logic [SPR_LOG2-1:0] offs(input logic [COORD_W-1:0] p,
                                               input logic [COORD_W-1:0] pos);
    logic [COORD_W-1:0] diff;
    diff = p - pos;
    return diff[SPR_LOG2-1:0];
  endfunction

  always_comb begin
    apple_hit = in_box(curr_x, applepos_x) && in_box(curr_y, applepos_y);
    head_hit  = (length != '0) && in_box(curr_x, snakepos_x[COORD_W-1:0])
                && in_box(curr_y, snakepos_y[COORD_W-1:0]);
    body_hit  = 1'b0;
    body_px   = '0;
    body_py   = '0;
    // Walk downwards so the lowest-index live segment wins.
    for (int i = MAX_SEG - 1; i >= 1; i--) begin
      if (i < int'(length) && in_box(curr_x, snakepos_x[COORD_W*i +: COORD_W])
          && in_box(curr_y, snakepos_y[COORD_W*i +: COORD_W])) begin
        body_hit = 1'b1;
        body_px  = snakepos_x[COORD_W*i +: COORD_W];
        body_py  = snakepos_y[COORD_W*i +: COORD_W];
      end
    end
  end

  always_comb begin
    spr_addr_d = '0;
    if (apple_hit) begin
      spr_addr_d = {offs(curr_y, applepos_y), offs(curr_x, applepos_x)};
    end else if (head_hit) begin
      spr_addr_d = {offs(curr_y, snakepos_y[COORD_W-1:0]), offs(curr_x, snakepos_x[COORD_W-1:0])};
    end else if (body_hit) begin
      spr_addr_d = {offs(curr_y, body_py), offs(curr_x, body_px)};
    end
    bg_col = curr_x[BG_W_LOG2-1:0] + scroll_q;
  end

  always_comb begin
    draw_d = '0;
    if (v2_q) begin
      case (state_q)
        StWin:   draw_d = WIN_RGB;
        StLose:  draw_d = LOSE_RGB;
        default: begin
          if (apple_hit2_q && apple_pix != TRANSP)     draw_d = apple_pix;
          else if (head_hit2_q && head_pix != TRANSP)  draw_d = head_pix;
          else if (body_hit2_q && body_pix != TRANSP)  draw_d = body_pix;
          else                                         draw_d = bg_pix;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      apple_hit_q  <= 1'b0;
      head_hit_q   <= 1'b0;
      body_hit_q   <= 1'b0;
      apple_hit2_q <= 1'b0;
      head_hit2_q  <= 1'b0;
      body_hit2_q  <= 1'b0;
      spr_addr     <= '0;
      bg_addr      <= '0;
      draw_valid   <= 1'b0;
      draw_r       <= '0;
      draw_g       <= '0;
      draw_b       <= '0;
    end else begin
      v1_q         <= pix_valid;
      apple_hit_q  <= apple_hit;
      head_hit_q   <= head_hit;
      body_hit_q   <= body_hit;
      spr_addr     <= spr_addr_d;
      bg_addr      <= {curr_y[BG_H_LOG2-1:0], bg_col};
      v2_q         <= v1_q;
      apple_hit2_q <= apple_hit_q;
      head_hit2_q  <= head_hit_q;
      body_hit2_q  <= body_hit_q;
      draw_valid   <= v2_q;
      draw_r       <= draw_d[11:8];
      draw_g       <= draw_d[7:4];
      draw_b       <= draw_d[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StPlay;
      div_q    <= '0;
      scroll_q <= '0;
    end else if (state_q == StPlay) begin
      if (lose)     state_q <= StLose;
      else if (win) state_q <= StWin;
      if (div_q == DIV_LAST) begin
        div_q    <= '0;
        scroll_q <= scroll_q + 1'b1;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor_pipe.sv
// Directed bench for sprite_compositor_pipe: latency, priority, transparency, edge, scroll, end screen.
module tb_sprite_compositor_pipe;
  localparam int CW = 11;
  localparam int MS = 23;

  logic           clk = 1'b0;
  logic           rst;
  logic           pix_valid;
  logic [CW-1:0]  curr_x, curr_y;
  logic [CW*MS-1:0] snakepos_x, snakepos_y;
  logic [5:0]     length;
  logic [CW-1:0]  applepos_x, applepos_y;
  logic           lose, win;
  logic [9:0]     spr_addr;
  logic [11:0]    bg_addr;
  logic [11:0]    apple_pix, head_pix, body_pix, bg_pix;
  logic [3:0]     draw_r, draw_g, draw_b;
  logic           draw_valid;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  sprite_compositor_pipe #(.SCROLL_DIV(4)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .curr_x(curr_x), .curr_y(curr_y),
    .snakepos_x(snakepos_x), .snakepos_y(snakepos_y), .length(length),
    .applepos_x(applepos_x), .applepos_y(applepos_y), .lose(lose), .win(win),
    .spr_addr(spr_addr), .bg_addr(bg_addr), .apple_pix(apple_pix), .head_pix(head_pix),
    .body_pix(body_pix), .bg_pix(bg_pix), .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .draw_valid(draw_valid)
  );

  // Drive one valid pixel and capture spr_addr after edge 1, draw_valid after edge 2, draw after edge 3.
  task automatic run_pixel(input logic [CW-1:0] x, input logic [CW-1:0] y,
                           output logic [9:0] sa, output logic [11:0] rgb,
                           output logic v_early, output logic v_on);
    @(negedge clk); pix_valid = 1'b1; curr_x = x; curr_y = y;
    @(negedge clk); pix_valid = 1'b0; sa = spr_addr;
    @(negedge clk); v_early = draw_valid;
    @(negedge clk); v_on = draw_valid; rgb = {draw_r, draw_g, draw_b};
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; pix_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic set_seg(input int i, input logic [CW-1:0] x, input logic [CW-1:0] y);
    snakepos_x[CW*i +: CW] = x;
    snakepos_y[CW*i +: CW] = y;
  endtask

  task automatic test_reset();
    logic [11:0] rgb;
    @(negedge clk); rst = 1'b1; pix_valid = 1'b1; curr_x = 300; curr_y = 300;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (draw_valid !== 1'b0 || {draw_r, draw_g, draw_b} !== 12'h000)
        $display("FAIL reset_draw: got valid=%b rgb=%h expected valid=0 rgb=000", draw_valid,
                 {draw_r, draw_g, draw_b});
      else passed++;
      checks++;
      if (spr_addr !== 10'h000 || bg_addr !== 12'h000)
        $display("FAIL reset_addr: got spr=%h bg=%h expected 000 000", spr_addr, bg_addr);
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (draw_valid !== 1'b0) $display("FAIL reset_latency2: got valid=%b expected 0", draw_valid);
    else passed++;
    @(negedge clk);
    rgb = {draw_r, draw_g, draw_b};
    checks++;
    if (draw_valid !== 1'b1 || rgb !== 12'h123)
      $display("FAIL reset_first_valid: got valid=%b rgb=%h expected valid=1 rgb=123", draw_valid, rgb);
    else passed++;
    // In-flight pixel hit by reset must never reach the output.
    @(negedge clk); pix_valid = 1'b1;
    @(negedge clk); pix_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (draw_valid !== 1'b0) $display("FAIL reset_discard: got valid=%b expected 0", draw_valid);
      else passed++;
    end
  endtask

  task automatic test_apple();
    logic [9:0] sa; logic [11:0] rgb; logic ve, vo;
    applepos_x = 100; applepos_y = 50; apple_pix = 12'hA51;
    run_pixel(105, 52, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h045) $display("FAIL apple_spr_addr: got %h expected 045", sa);
    else passed++;
    checks++;
    if (ve !== 1'b0 || vo !== 1'b1)
      $display("FAIL apple_latency: got early=%b on=%b expected 0 1", ve, vo);
    else passed++;
    checks++;
    if (rgb !== 12'hA51) $display("FAIL apple_rgb: got %h expected A51", rgb);
    else passed++;
    @(negedge clk);
    checks++;
    if (draw_valid !== 1'b0 || {draw_r, draw_g, draw_b} !== 12'h000)
      $display("FAIL blanking: got valid=%b rgb=%h expected 0 000", draw_valid, {draw_r, draw_g, draw_b});
    else passed++;
  endtask

  task automatic test_apple_over_head();
    logic [9:0] sa; logic [11:0] rgb; logic ve, vo;
    applepos_x = 64; applepos_y = 64; set_seg(0, 64, 64); length = 1;
    apple_pix = 12'h000; head_pix = 12'h3C3;
    run_pixel(64, 64, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h000 || rgb !== 12'h3C3)
      $display("FAIL apple_transp_head: got spr=%h rgb=%h expected 000 3C3", sa, rgb);
    else passed++;
    head_pix = 12'h000;
    run_pixel(70, 65, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h026 || rgb !== 12'h123)
      $display("FAIL all_transp_bg: got spr=%h rgb=%h expected 026 123", sa, rgb);
    else passed++;
  endtask

  task automatic test_body_priority();
    logic [9:0] sa; logic [11:0] rgb; logic ve, vo;
    applepos_x = 1000; applepos_y = 1000; apple_pix = 12'hA51; head_pix = 12'h3C3;
    body_pix = 12'h7B2;
    set_seg(0, 500, 500); set_seg(1, 200, 200); set_seg(2, 210, 200); length = 3;
    run_pixel(215, 205, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h0AF || rgb !== 12'h7B2)
      $display("FAIL body_lowest_seg: got spr=%h rgb=%h expected 0AF 7B2", sa, rgb);
    else passed++;
    run_pixel(235, 207, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h0F9 || rgb !== 12'h7B2)
      $display("FAIL body_seg2: got spr=%h rgb=%h expected 0F9 7B2", sa, rgb);
    else passed++;
    length = 2;
    run_pixel(235, 207, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h000 || rgb !== 12'h123)
      $display("FAIL body_dead_seg: got spr=%h rgb=%h expected 000 123", sa, rgb);
    else passed++;
  endtask

  task automatic test_edge_no_wrap();
    logic [9:0] sa; logic [11:0] rgb; logic ve, vo;
    length = 0; applepos_x = 2016; applepos_y = 0; apple_pix = 12'hA51;
    run_pixel(5, 0, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h000 || rgb !== 12'h123)
      $display("FAIL edge_no_wrap: got spr=%h rgb=%h expected 000 123", sa, rgb);
    else passed++;
    run_pixel(2047, 0, sa, rgb, ve, vo);
    checks++;
    if (sa !== 10'h01F || rgb !== 12'hA51)
      $display("FAIL edge_last_col: got spr=%h rgb=%h expected 01F A51", sa, rgb);
    else passed++;
  endtask

  task automatic test_scroll_and_lose();
    logic [11:0] obs [1:9];
    logic [9:0] sa; logic [11:0] rgb; logic ve, vo;
    @(negedge clk); rst = 1'b1; pix_valid = 1'b0; curr_x = 10; curr_y = 70;
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk); obs[c] = bg_addr;
    end
    checks++;
    if (obs[4] !== 12'd394) $display("FAIL scroll_step0: got %0d expected 394", obs[4]);
    else passed++;
    checks++;
    if (obs[5] !== 12'd395) $display("FAIL scroll_step1: got %0d expected 395", obs[5]);
    else passed++;
    checks++;
    if (obs[9] !== 12'd396) $display("FAIL scroll_step2: got %0d expected 396", obs[9]);
    else passed++;
    win = 1'b1; lose = 1'b1;
    @(negedge clk); win = 1'b0; lose = 1'b0;
    applepos_x = 100; applepos_y = 50;
    run_pixel(105, 52, sa, rgb, ve, vo);
    checks++;
    if (vo !== 1'b1 || rgb !== 12'hF00)
      $display("FAIL lose_priority: got valid=%b rgb=%h expected 1 F00", vo, rgb);
    else passed++;
    win = 1'b1;
    @(negedge clk); win = 1'b0;
    run_pixel(105, 52, sa, rgb, ve, vo);
    checks++;
    if (rgb !== 12'hF00) $display("FAIL lose_sticky: got %h expected F00", rgb);
    else passed++;
    curr_x = 10; curr_y = 70;
    repeat (9) @(negedge clk);
    checks++;
    if (bg_addr !== 12'd396) $display("FAIL scroll_frozen: got %0d expected 396", bg_addr);
    else passed++;
  endtask

  task automatic test_win();
    logic [9:0] sa; logic [11:0] rgb; logic ve, vo;
    do_reset();
    win = 1'b1;
    @(negedge clk); win = 1'b0;
    set_seg(0, 64, 64); length = 1; head_pix = 12'h3C3;
    run_pixel(64, 64, sa, rgb, ve, vo);
    checks++;
    if (vo !== 1'b1 || rgb !== 12'h0F0)
      $display("FAIL win_screen: got valid=%b rgb=%h expected 1 0F0", vo, rgb);
    else passed++;
    @(negedge clk);
    checks++;
    if ({draw_r, draw_g, draw_b} !== 12'h000)
      $display("FAIL win_blanking: got %h expected 000", {draw_r, draw_g, draw_b});
    else passed++;
  endtask

  initial begin
    rst = 1'b0; pix_valid = 1'b0; curr_x = '0; curr_y = '0;
    snakepos_x = '0; snakepos_y = '0; length = 0;
    applepos_x = 1000; applepos_y = 1000; lose = 1'b0; win = 1'b0;
    apple_pix = 12'hA51; head_pix = 12'h3C3; body_pix = 12'h7B2; bg_pix = 12'h123;
    test_reset();
    test_apple();
    test_apple_over_head();
    test_body_priority();
    test_edge_no_wrap();
    test_scroll_and_lose();
    test_win();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
